video_to_axis: RTL

VIDEO_TO_AXIS -- requirements
Module: video_to_axis

---
 rtl/video_to_axis.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/video_to_axis.sv
// ---------------------------------------------------------------------------
// video_to_axis
//
// Converts a parallel RGB video pixel stream into an AXI4-Stream. A frame is
// opened by the rising edge of i_frame_start, which latches the active
// resolution. Each qualified pixel is then tagged with start-of-frame and
// end-of-line flags and written into a small first-word-fall-through
// buffer. That buffer absorbs downstream back-pressure.
//
// Optional build feature:
//   VIDEO_TO_AXIS_STATUS_EN - when defined, o_overflow and o_frame_err are
//                             sticky status flags that only reset clears.
//                             When undefined, both outputs are tied low and
//                             no status registers exist.
//
// Parameters:
//   C_WIDTH     - bits per colour component
//   TUSER_WIDTH - tuser width; bit 0 = SOF, upper bits are always 0
//   FIFO_DEPTH  - buffer entries (power of two, at least 4)
//
// Ports:
//   i_video_clk       sole clock
//   i_video_reset_n   asynchronous active-low reset
//   i_frame_start     frame start strobe (level may be held; the edge counts)
//   i_data_valid      pixel qualifier
//   i_R/i_G/i_B       pixel components
//   i_hres/i_vres     active pixels per line / lines per frame
//   o_tdata           {R, G, B}; B occupies the least significant component
//   o_tvalid/i_tready AXI4-Stream handshake
//   o_tlast           end of line
//   o_tuser           bit 0 = start of frame
//   o_overflow        sticky: a pixel was dropped because the buffer was full
//   o_frame_err       sticky: a frame was truncated or a stray pixel arrived
// ---------------------------------------------------------------------------
module video_to_axis #(
    parameter int C_WIDTH     = 8,
    parameter int TUSER_WIDTH = 2,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                   i_video_clk,
    input  logic                   i_video_reset_n,
    input  logic                   i_frame_start,
    input  logic                   i_data_valid,
    input  logic [C_WIDTH-1:0]     i_R,
    input  logic [C_WIDTH-1:0]     i_G,
    input  logic [C_WIDTH-1:0]     i_B,
    input  logic [11:0]            i_hres,
    input  logic [11:0]            i_vres,
    output logic [3*C_WIDTH-1:0]   o_tdata,
    output logic                   o_tvalid,
    input  logic                   i_tready,
    output logic                   o_tlast,
    output logic [TUSER_WIDTH-1:0] o_tuser,
    output logic                   o_overflow,
    output logic                   o_frame_err
);

    localparam int          PIX_W   = 3 * C_WIDTH;
    localparam int          ENT_W   = PIX_W + 2;
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Frame tracking state
    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_fs_prev;
    logic [11:0] r_hres;
    logic [11:0] r_vres;
    logic [11:0] r_x;
    logic [11:0] r_y;
    logic        r_sof;
    logic [11:0] w_hres_nxt;
    logic [11:0] w_vres_nxt;
    logic [11:0] w_x_nxt;
    logic [11:0] w_y_nxt;
    logic        w_sof_nxt;

    logic        w_fs_edge;
    logic        w_pix_in;
    logic        w_eol;
    logic        w_eof;
    logic [11:0] w_hres_m1;
    logic [11:0] w_vres_m1;

    // Output buffer
    logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_tvalid;
    logic [ENT_W-1:0] w_head;

    // A held level is not a new frame: only a 0 -> 1 transition counts.
    assign w_fs_edge = i_frame_start & ~r_fs_prev;

    // The guard keeps the idle-time value defined when a zero resolution was
    // latched; ACTIVE never runs with a zero resolution.
    assign w_hres_m1 = (r_hres != 12'd0) ? (r_hres - 12'd1) : 12'd0;
    assign w_vres_m1 = (r_vres != 12'd0) ? (r_vres - 12'd1) : 12'd0;

    assign w_eol = (r_x == w_hres_m1);
    assign w_eof = w_eol && (r_y == w_vres_m1);

    // A pixel that coincides with a frame-start edge belongs to neither the
    // old frame nor the new frame, so it is discarded.
    assign w_pix_in = (r_state == ST_ACTIVE) && i_data_valid && !w_fs_edge;

    assign w_tvalid = (r_count != '0);
    assign w_full   = (r_count == DEPTH_C);
    assign w_pop    = w_tvalid && i_tready;
    // A full buffer still accepts a write when the head leaves in the same cycle.
    assign w_push   = w_pix_in && (!w_full || w_pop);

    always_comb begin
        w_state_nxt = r_state;
        w_hres_nxt  = r_hres;
        w_vres_nxt  = r_vres;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_sof_nxt   = r_sof;

        if (w_fs_edge) begin
            w_hres_nxt  = i_hres;
            w_vres_nxt  = i_vres;
            w_x_nxt     = 12'd0;
            w_y_nxt     = 12'd0;
            w_sof_nxt   = 1'b1;
            w_state_nxt = ((i_hres != 12'd0) && (i_vres != 12'd0)) ? ST_ACTIVE : ST_IDLE;
        end else if (w_pix_in) begin
            // A dropped pixel still advances the raster position, which keeps
            // tlast aligned with the real line boundaries.
            if (w_push) begin
                w_sof_nxt = 1'b0;
            end
            if (w_eol) begin
                w_x_nxt = 12'd0;
                if (w_eof) begin
                    w_y_nxt     = 12'd0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_y_nxt = r_y + 12'd1;
                end
            end else begin
                w_x_nxt = r_x + 12'd1;
            end
        end
    end

    always_ff @(posedge i_video_clk or negedge i_video_reset_n) begin
        if (!i_video_reset_n) begin
            r_state   <= ST_IDLE;
            r_fs_prev <= 1'b0;
            r_hres    <= 12'd0;
            r_vres    <= 12'd0;
            r_x       <= 12'd0;
            r_y       <= 12'd0;
            r_sof     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_fs_prev <= i_frame_start;
            r_hres    <= w_hres_nxt;
            r_vres    <= w_vres_nxt;
            r_x       <= w_x_nxt;
            r_y       <= w_y_nxt;
            r_sof     <= w_sof_nxt;
        end
    end

    always_ff @(posedge i_video_clk or negedge i_video_reset_n) begin
        if (!i_video_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

    // Storage carries only data. Reset does not clear it because the outputs
    // are masked whenever the buffer is empty.
    always_ff @(posedge i_video_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_sof, w_eol, i_R, i_G, i_B};
        end
    end

    // First-word-fall-through: the head entry is presented directly. The
    // head only moves on a pop, so the outputs hold steady under back-pressure.
    assign w_head = r_mem[r_rd_ptr];

    assign o_tvalid = w_tvalid;
    assign o_tdata  = w_tvalid ? w_head[PIX_W-1:0] : '0;
    assign o_tlast  = w_tvalid & w_head[PIX_W];

    always_comb begin
        o_tuser    = '0;
        o_tuser[0] = w_tvalid & w_head[PIX_W+1];
    end

`ifdef VIDEO_TO_AXIS_STATUS_EN
    logic w_drop;
    logic w_stray;
    logic w_restart_err;
    logic r_overflow;
    logic r_frame_err;

    assign w_drop        = w_pix_in && !w_push;
    assign w_stray       = (r_state == ST_IDLE) && i_data_valid && !w_fs_edge;
    assign w_restart_err = w_fs_edge && (r_state == ST_ACTIVE);

    always_ff @(posedge i_video_clk or negedge i_video_reset_n) begin
        if (!i_video_reset_n) begin
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_stray || w_restart_err) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    assign o_overflow  = r_overflow;
    assign o_frame_err = r_frame_err;
`else
    assign o_overflow  = 1'b0;
    assign o_frame_err = 1'b0;
`endif

endmodule
